enable_debouncer: RTL and testbench

- Upstream conditioning stage for the 8-bit event counter.
- Takes a raw, asynchronous, bouncy button/event line, synchronizes it and debounces it with a 4-state FSM.
- Emits single-cycle `enable` pulses that drive the counter's enable input directly, with optional auto-repeat while the input is held.
- Also exports the clean debounced level.

---
 rtl/enable_debouncer_if.sv | 22 ++
 rtl/enable_debouncer.sv | 138 +++++++++++++
 tb/tb_enable_debouncer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/enable_debouncer_if.sv
// Button-side bundle of the enable debouncer: raw input and repeat control in,
// counter enable pulse and clean level out.
interface enable_debouncer_if;
  logic btn_in;
  logic repeat_en;
  logic enable;
  logic level;

  modport master (
    output btn_in,
    output repeat_en,
    input  enable,
    input  level
  );

  modport slave (
    input  btn_in,
    input  repeat_en,
    output enable,
    output level
  );
endinterface

// File: rtl/enable_debouncer.sv
// Synchronizes and debounces a raw button line, emitting one-cycle enable pulses
// per accepted press plus optional auto-repeat while held; also exports the level.
module enable_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic               clk,
  input  logic               rst,
  enable_debouncer_if.slave  bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DMAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RDELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPERIOD = RW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_e                 state_q, state_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   rep_q, rep_d;
  logic                   enable_q, enable_d;
  logic                   level_q, level_d;
  logic [RW-1:0]          rcnt_inc;
  logic [RW-1:0]          rtarget;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign rcnt_inc = rcnt_q + RW'(1);
  // First pulse after entering HELD waits the full delay, later ones the period.
  assign rtarget  = rep_q ? RPERIOD : RDELAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      rep_q    <= 1'b0;
      enable_q <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      rep_q    <= rep_d;
      enable_q <= enable_d;
      level_q  <= level_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    rep_d    = rep_q;
    enable_d = 1'b0;
    level_d  = level_q;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          dcnt_d  = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DMAX) begin
          state_d  = HELD;
          enable_d = 1'b1;
          level_d  = 1'b1;
          dcnt_d   = '0;
          rcnt_d   = '0;
          rep_d    = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DW'(1);
          rcnt_d  = '0;
          rep_d   = 1'b0;
        end else if (!bus.repeat_en) begin
          rcnt_d = '0;
          rep_d  = 1'b0;
        end else if (rcnt_inc == rtarget) begin
          enable_d = 1'b1;
          rcnt_d   = '0;
          rep_d    = 1'b1;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
          dcnt_d  = '0;
          rcnt_d  = '0;
          rep_d   = 1'b0;
        end else if (dcnt_q == DMAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        rcnt_d  = '0;
        rep_d   = 1'b0;
        level_d = 1'b0;
      end
    endcase
  end

  assign bus.enable = enable_q;
  assign bus.level  = level_q;

endmodule

// File: tb/tb_enable_debouncer.sv
// Directed test-plan scenarios followed by random button traffic, all checked
// cycle by cycle against a run-length reference model of the debouncer.
module tb_enable_debouncer;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;

  enable_debouncer_if bus();

  enable_debouncer #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;
  int pulses[$];
  int rise_e[$];
  int fall_e[$];
  logic prev_lvl = 1'b0;

  // Reference model: btn samples delayed S edges, level flips once the input
  // disagrees with it for D+1 consecutive edges, repeat counted as hold time.
  bit hist[S];
  bit m_level;
  int m_run;
  int m_hold;
  bit m_pulse;

  function automatic void model_reset();
    for (int i = 0; i < S; i++) hist[i] = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    m_hold  = 0;
    m_pulse = 1'b0;
  endfunction

  function automatic void model_edge(input bit b, input bit r);
    bit s;
    bit held;
    s    = hist[S-1];
    held = m_level && (m_run == 0);
    for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = b;
    m_pulse = 1'b0;
    if (held && s && r) begin
      m_hold++;
      if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0)) m_pulse = 1'b1;
    end else begin
      m_hold = 0;
    end
    if (s != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = s;
        m_run   = 0;
        if (s) m_pulse = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_obs();
    pulses.delete();
    rise_e.delete();
    fall_e.delete();
  endtask

  // Called at a negedge: drive, let one edge happen, check at the next negedge.
  task automatic cycle(input bit b, input bit r);
    bus.btn_in    = b;
    bus.repeat_en = r;
    @(posedge clk);
    edge_n++;
    model_edge(b, r);
    @(negedge clk);
    chk_bit("enable", bus.enable, m_pulse);
    chk_bit("level", bus.level, m_level);
    if (bus.enable === 1'b1) pulses.push_back(edge_n);
    if (bus.level !== prev_lvl) begin
      if (bus.level === 1'b1) rise_e.push_back(edge_n);
      else fall_e.push_back(edge_n);
      prev_lvl = bus.level;
    end
  endtask

  task automatic do_reset(input int nedges);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk_bit("rst_enable", bus.enable, 1'b0);
    chk_bit("rst_level", bus.level, 1'b0);
    prev_lvl = 1'b0;
    repeat (nedges) begin
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int e0, e1, h, d0;
    int win[$];
    bit b, r;

    rst           = 1'b1;
    bus.btn_in    = 1'b0;
    bus.repeat_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_bit("reset_enable", bus.enable, 1'b0);
    chk_bit("reset_level", bus.level, 1'b0);
    rst = 1'b0;

    // Clean press and release without repeat
    repeat (4) cycle(1'b0, 1'b0);
    clear_obs();
    e0 = edge_n + 1;
    repeat (20) cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);
    chk_int("t1_npulse", pulses.size(), 1);
    chk_int("t1_pulse_edge", at(pulses, 0), e0 + 6);
    chk_int("t1_rise_edge", at(rise_e, 0), e0 + 6);
    chk_int("t1_fall_edge", at(fall_e, 0), e0 + 26);

    // Short glitch never qualifies
    clear_obs();
    repeat (3) cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    chk_int("t2_npulse", pulses.size(), 0);
    chk_int("t2_nrise", rise_e.size(), 0);

    // Press bounce restarts qualification
    clear_obs();
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    e1 = edge_n + 1;
    repeat (12) cycle(1'b1, 1'b0);
    chk_int("t3_npulse", pulses.size(), 1);
    chk_int("t3_pulse_edge", at(pulses, 0), e1 + 6);
    repeat (12) cycle(1'b0, 1'b0);

    // Auto-repeat while held
    clear_obs();
    e0 = edge_n + 1;
    h  = e0 + 6;
    repeat (37) cycle(1'b1, 1'b1);
    repeat (14) cycle(1'b0, 1'b1);
    win.delete();
    foreach (pulses[i]) if (pulses[i] >= h && pulses[i] <= h + 30) win.push_back(pulses[i]);
    chk_int("t4_npulse", win.size(), 8);
    chk_int("t4_first", at(win, 0), h);
    for (int k = 0; k < 7; k++) chk_int("t4_repeat", at(win, k + 1), h + 10 + 3 * k);

    // Release bounce keeps the level high
    repeat (12) cycle(1'b1, 1'b0);
    clear_obs();
    repeat (2) cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0);
    chk_int("t5_npulse", pulses.size(), 0);
    chk_int("t5_nfall", fall_e.size(), 0);
    chk_bit("t5_level", bus.level, 1'b1);

    // Reset while held clears the level at once
    do_reset(2);
    repeat (12) cycle(1'b0, 1'b0);

    // Reset mid-debounce, then full re-qualification
    e0 = edge_n + 1;
    repeat (4) cycle(1'b1, 1'b0);
    do_reset(2);
    clear_obs();
    d0 = edge_n + 1;
    repeat (12) cycle(1'b1, 1'b0);
    chk_int("t6_npulse", pulses.size(), 1);
    chk_int("t6_pulse_edge", at(pulses, 0), d0 + 6);
    repeat (12) cycle(1'b0, 1'b0);

    // Random traffic against the model
    r = 1'b0;
    for (int seg = 0; seg < 200; seg++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r = ~r;
      if ($urandom_range(0, 39) == 0) do_reset(1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) cycle(b, r);
      else repeat ($urandom_range(6, 30)) cycle(b, r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
